ex_mem_stage: RTL
=================

Name: ex_mem_stage

Overview:
- EX/MEM pipeline register directly downstream of the main ALU in the 5-stage datapath.
- Captures the 32-bit ALU result, the overflow flag and the control bundle from EX.
- Splits SWAP results into two sequential register writes and stalls EX for the extra cycle.
- Converts ADD/SUB overflow into a one-cycle trap with the faulting PC latched, and suppresses that instruction's side effects.

Parameters:
- DATA_W, 16, datapath width; the ALU result input is 2*DATA_W bits.
- REG_AW, 4, register-file address width.
- PC_W, 16, program counter width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ex_valid  input  1  EX holds a valid instruction this cycle.
- ex_pc  input  PC_W  PC of the EX instruction.
- ex_alu_op  input  3  ALU control: 000 ADD, 001 SUB, 010 MOVE, 011 SWAP, 1xx logic.
- ex_result  input  2*DATA_W  ALU result; upper half is meaningful only for SWAP.
- ex_overflow  input  1  ALU overflow flag.
- ex_rd  input  REG_AW  primary destination register.
- ex_rs  input  REG_AW  SWAP second destination register.
- ex_reg_write  input  1  instruction writes the register file.
- ex_mem_read  input  1  load.
- ex_mem_write  input  1  store.
- ex_store_data  input  DATA_W  store data.
- mem_stall  input  1  MEM cannot accept; hold all state.
- flush  input  1  kill the EX instruction and any pending SWAP half.
- ex_stall  output  1  EX must hold its instruction.
- mem_valid  output  1  MEM holds a valid instruction.
- mem_alu_out  output  DATA_W  address or result to MEM.
- mem_wr_reg  output  REG_AW  write-back register.
- mem_reg_write, mem_mem_read, mem_mem_write  output  1 each  registered control.
- mem_store_data  output  DATA_W  registered store data.
- ovf_trap  output  1  one-cycle overflow trap pulse.
- epc  output  PC_W  PC of the last trapping instruction.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, state PASS, the saved upper half cleared. epc also resets to 0.
- All outputs are registered. Latency from EX to MEM is 1 cycle.
- Priority order: rst > flush > mem_stall > normal capture.

State PASS:
- If ex_valid and not stalled, capture the instruction: mem_alu_out = ex_result[DATA_W-1:0], mem_wr_reg = ex_rd, and all control bits pass through.
- If !ex_valid, mem_valid = 0 and all control outputs = 0.
- SWAP (op 011) with ex_reg_write: the first half is captured as above, ex_result[2*DATA_W-1:DATA_W] and ex_rs are saved, and the state moves to SWAP2.
- ex_stall = 1 combinationally whenever the state is SWAP2 or mem_stall = 1.

State SWAP2:
- On the next non-stalled edge, issue mem_alu_out = saved upper half, mem_wr_reg = saved rs, mem_reg_write = 1, mem_mem_read = 0, mem_mem_write = 0.
- Return to PASS. EX's held instruction is captured on the following edge.

Overflow trap:
- Applies when ex_valid, op is 000 or 001, and ex_overflow = 1.
- The instruction is captured with mem_valid = 1 but mem_reg_write, mem_mem_read and mem_mem_write forced to 0.
- ovf_trap = 1 for exactly one cycle and epc <= ex_pc.
- ex_overflow is ignored for all other ops.

flush:
- Next edge: mem_valid = 0, all control outputs = 0, state = PASS, ovf_trap = 0.
- A flush during SWAP2 drops the second write.
- A flush takes precedence over an overflow in the same cycle: no trap, epc unchanged.

mem_stall:
- All registers and state hold, including the SWAP2 state.
- ovf_trap is a single pulse per trapping instruction: it drops after its first cycle even while stalled.

Simultaneous SWAP and overflow is impossible (op-gated). No other error conditions.

Optional Feature:
- Macro: EX_MEM_FWD_EN.
- When defined: adds outputs fwd_valid (1), fwd_rd (REG_AW) and fwd_data (DATA_W).
  - These are combinational copies of mem_valid & mem_reg_write, mem_wr_reg and mem_alu_out.
  - fwd_valid is forced to 0 while mem_mem_read = 1, because load data is not yet available.
  - They feed the EX forwarding mux.
- When undefined: these ports do not exist and there is no added logic.

Decomposition:
- Shared package holds:
  - ALU op encodings: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_MOVE=3'b010, ALU_SWAP=3'b011, ALU_AND=3'b100, ALU_OR=3'b101.
  - DATA_W, REG_AW and PC_W defaults.
  - The state typedef {ST_PASS, ST_SWAP2}.
- One natural sub-module, ex_mem_swap_seq: the 2-state sequencer owning the saved upper half, saved rs and ex_stall generation. The main module holds the pipeline register and trap logic.

Test Plan:
- ADD with A=0x0003, B=0x0004, ex_result=0x00000007, rd=5, reg_write=1 -> next cycle mem_alu_out=0x0007, mem_wr_reg=5, mem_reg_write=1, mem_valid=1.
- SWAP with ex_result=0x1234ABCD, rd=2, rs=7 -> cycle 1: out 0xABCD to r2 with ex_stall=1; cycle 2: out 0x1234 to r7; ex_stall drops after cycle 2.
- SUB with ex_overflow=1, ex_pc=0x0040 -> ovf_trap high exactly 1 cycle, epc=0x0040, mem_reg_write=0, mem_valid=1.
- SWAP followed by flush asserted during SWAP2 -> second write is never issued, mem_valid=0, state back to PASS, ex_stall=0.
- mem_stall held for 3 cycles mid-SWAP2 -> outputs frozen; the 0x1234 write issues on the first edge after mem_stall drops.
- Assert rst asynchronously mid-SWAP2 -> all outputs 0 immediately; the first instruction after release passes with 1-cycle latency.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// Shared types and encodings for the EX/MEM pipeline register slice.
// Optional forwarding outputs are enabled with EX_MEM_FWD_EN.
package ex_mem_stage_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_REG_AW = 4;
    localparam int DEF_PC_W   = 16;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_MOVE = 3'b010;
    localparam logic [2:0] ALU_SWAP = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;

    typedef enum logic {
        ST_PASS,
        ST_SWAP2
    } state_t;

    // Only ADD/SUB can raise an overflow trap.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX-side inputs and MEM-side outputs of the EX/MEM register.
// Forwarding signals exist only when EX_MEM_FWD_EN is defined.
interface ex_mem_stage_if
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int PC_W   = DEF_PC_W
);
    logic                ex_valid;
    logic [PC_W-1:0]     ex_pc;
    logic [2:0]          ex_alu_op;
    logic [2*DATA_W-1:0] ex_result;
    logic                ex_overflow;
    logic [REG_AW-1:0]   ex_rd;
    logic [REG_AW-1:0]   ex_rs;
    logic                ex_reg_write;
    logic                ex_mem_read;
    logic                ex_mem_write;
    logic [DATA_W-1:0]   ex_store_data;
    logic                mem_stall;
    logic                flush;
    logic                ex_stall;
    logic                mem_valid;
    logic [DATA_W-1:0]   mem_alu_out;
    logic [REG_AW-1:0]   mem_wr_reg;
    logic                mem_reg_write;
    logic                mem_mem_read;
    logic                mem_mem_write;
    logic [DATA_W-1:0]   mem_store_data;
    logic                ovf_trap;
    logic [PC_W-1:0]     epc;
`ifdef EX_MEM_FWD_EN
    logic                fwd_valid;
    logic [REG_AW-1:0]   fwd_rd;
    logic [DATA_W-1:0]   fwd_data;
`endif

    modport master (
        output ex_valid, ex_pc, ex_alu_op, ex_result, ex_overflow,
        output ex_rd, ex_rs, ex_reg_write, ex_mem_read, ex_mem_write,
        output ex_store_data, mem_stall, flush,
        input  ex_stall, mem_valid, mem_alu_out, mem_wr_reg,
        input  mem_reg_write, mem_mem_read, mem_mem_write,
        input  mem_store_data, ovf_trap, epc
`ifdef EX_MEM_FWD_EN
        ,
        input  fwd_valid, fwd_rd, fwd_data
`endif
    );

    modport slave (
        input  ex_valid, ex_pc, ex_alu_op, ex_result, ex_overflow,
        input  ex_rd, ex_rs, ex_reg_write, ex_mem_read, ex_mem_write,
        input  ex_store_data, mem_stall, flush,
        output ex_stall, mem_valid, mem_alu_out, mem_wr_reg,
        output mem_reg_write, mem_mem_read, mem_mem_write,
        output mem_store_data, ovf_trap, epc
`ifdef EX_MEM_FWD_EN
        ,
        output fwd_valid, fwd_rd, fwd_data
`endif
    );

endinterface

// File: rtl/ex_mem_swap_seq.sv
// Two-state SWAP sequencer: holds the upper result half and rs,
// and stalls EX while the second register write is pending.
module ex_mem_swap_seq
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [2:0]        ex_alu_op,
    input  logic              ex_reg_write,
    input  logic [DATA_W-1:0] ex_hi,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic              mem_stall,
    input  logic              flush,
    output logic              swap2,
    output logic [DATA_W-1:0] saved_hi,
    output logic [REG_AW-1:0] saved_rs,
    output logic              ex_stall
);
    state_t state, state_n;
    logic   start;
    logic   load;

    assign start    = ex_valid && ex_reg_write && (ex_alu_op == ALU_SWAP);
    assign load     = (state == ST_PASS) && start && !flush && !mem_stall;
    assign swap2    = (state == ST_SWAP2);
    assign ex_stall = swap2 || mem_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_PASS;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            saved_hi <= '0;
            saved_rs <= '0;
        end else if (load) begin
            saved_hi <= ex_hi;
            saved_rs <= ex_rs;
        end
    end

    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = ST_PASS;
        end else if (!mem_stall) begin
            unique case (state)
                ST_PASS:  if (start) state_n = ST_SWAP2;
                ST_SWAP2: state_n = ST_PASS;
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with SWAP split and ADD/SUB overflow trap.
// Define EX_MEM_FWD_EN to add the fwd_* forwarding outputs.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int PC_W   = DEF_PC_W
) (
    input logic          clk,
    input logic          rst,
    ex_mem_stage_if.slave bus
);
    logic              swap2;
    logic [DATA_W-1:0] saved_hi;
    logic [REG_AW-1:0] saved_rs;
    logic              stall_out;
    logic              trap;

    logic              valid_q;
    logic [DATA_W-1:0] alu_q;
    logic [REG_AW-1:0] wr_q;
    logic              rw_q;
    logic              mr_q;
    logic              mw_q;
    logic [DATA_W-1:0] sd_q;
    logic              trap_q;
    logic [PC_W-1:0]   epc_q;

    ex_mem_swap_seq #(
        .DATA_W(DATA_W),
        .REG_AW(REG_AW)
    ) u_seq (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (bus.ex_valid),
        .ex_alu_op    (bus.ex_alu_op),
        .ex_reg_write (bus.ex_reg_write),
        .ex_hi        (bus.ex_result[2*DATA_W-1:DATA_W]),
        .ex_rs        (bus.ex_rs),
        .mem_stall    (bus.mem_stall),
        .flush        (bus.flush),
        .swap2        (swap2),
        .saved_hi     (saved_hi),
        .saved_rs     (saved_rs),
        .ex_stall     (stall_out)
    );

    assign trap = bus.ex_valid && is_arith(bus.ex_alu_op) && bus.ex_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            alu_q   <= '0;
            wr_q    <= '0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            sd_q    <= '0;
            trap_q  <= 1'b0;
            epc_q   <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            trap_q  <= 1'b0;
        end else if (bus.mem_stall) begin
            // Trap is a single pulse even when MEM holds the instruction.
            trap_q  <= 1'b0;
        end else if (swap2) begin
            valid_q <= 1'b1;
            alu_q   <= saved_hi;
            wr_q    <= saved_rs;
            rw_q    <= 1'b1;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            trap_q  <= 1'b0;
        end else if (bus.ex_valid) begin
            valid_q <= 1'b1;
            alu_q   <= bus.ex_result[DATA_W-1:0];
            wr_q    <= bus.ex_rd;
            sd_q    <= bus.ex_store_data;
            rw_q    <= bus.ex_reg_write && !trap;
            mr_q    <= bus.ex_mem_read && !trap;
            mw_q    <= bus.ex_mem_write && !trap;
            trap_q  <= trap;
            if (trap) epc_q <= bus.ex_pc;
        end else begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            trap_q  <= 1'b0;
        end
    end

    assign bus.ex_stall       = stall_out;
    assign bus.mem_valid      = valid_q;
    assign bus.mem_alu_out    = alu_q;
    assign bus.mem_wr_reg     = wr_q;
    assign bus.mem_reg_write  = rw_q;
    assign bus.mem_mem_read   = mr_q;
    assign bus.mem_mem_write  = mw_q;
    assign bus.mem_store_data = sd_q;
    assign bus.ovf_trap       = trap_q;
    assign bus.epc            = epc_q;

`ifdef EX_MEM_FWD_EN
    // Load results are not available yet, so never forward them.
    assign bus.fwd_valid = valid_q && rw_q && !mr_q;
    assign bus.fwd_rd    = wr_q;
    assign bus.fwd_data  = alu_q;
`endif

endmodule
